reg_dump_tx: RTL

//   Reads back the debug registry over UART. On a trigger it snapshots the packed

---
 rtl/reg_dump_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_dump_tx.sv
// ============================================================================
// Module      : reg_dump_tx
// Description : Snapshots a packed register bank on trigger and streams a
//               header / register bytes / XOR checksum frame to a UART Tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_tx #(
  parameter int                           C_UART_DATA_WIDTH = 8,
  parameter int                           C_REG_WIDTH       = 4,
  parameter int                           C_REG_COUNT       = 4,
  parameter logic [C_UART_DATA_WIDTH-1:0] C_HEADER          = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_trigger,
  input  logic [C_REG_COUNT*C_REG_WIDTH-1:0]   i_regs,
  output logic                                 o_send,
  output logic [C_UART_DATA_WIDTH-1:0]         o_data,
  input  logic                                 i_ack,
  input  logic                                 i_tx_error,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Index of the checksum byte; the header sits at index 0.
  localparam logic [7:0] c_LAST_IDX = 8'(C_REG_COUNT + 1);

  state_t                               r_state;
  state_t                               w_next;
  logic [C_REG_COUNT*C_REG_WIDTH-1:0]   r_snap;
  logic [7:0]                           r_idx;
  logic [C_UART_DATA_WIDTH-1:0]         r_csum;
  logic                                 r_abort;
  logic [C_UART_DATA_WIDTH-1:0]         w_byte;
  logic                                 w_take;
  logic                                 w_err;

  // txError has priority over ack in the same cycle.
  assign w_err  = ((r_state == S_SEND) || (r_state == S_GAP)) && i_tx_error;
  assign w_take = (r_state == S_SEND) && i_ack && !i_tx_error;

  always_comb begin
    w_byte = '0;
    if (r_idx == 8'd0) begin
      w_byte = C_HEADER;
    end else if (r_idx == c_LAST_IDX) begin
      w_byte = r_csum;
    end else begin
      for (int k = 0; k < C_REG_COUNT; k++) begin
        if (r_idx == 8'(k + 1)) begin
          w_byte[C_REG_WIDTH-1:0] = r_snap[k*C_REG_WIDTH +: C_REG_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_abort <= w_err;
      if ((r_state == S_IDLE) && i_trigger) begin
        r_snap <= i_regs;
        r_idx  <= '0;
        r_csum <= '0;
      end else if (w_take) begin
        r_csum <= r_csum ^ w_byte;
        r_idx  <= r_idx + 8'd1;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    o_send  = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_abort = r_abort;
    o_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_trigger) w_next = S_SEND;
      end
      S_SEND: begin
        o_send = 1'b1;
        o_busy = 1'b1;
        o_data = w_byte;
        if (i_tx_error) begin
          w_next = S_IDLE;
        end else if (i_ack) begin
          w_next = (r_idx == c_LAST_IDX) ? S_FIN : S_GAP;
        end
      end
      S_GAP: begin
        o_busy = 1'b1;
        w_next = i_tx_error ? S_IDLE : S_SEND;
      end
      S_FIN: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
